// File: rtl/lab6_practice_slave.sv
// Slave end of the lab6 link: synchronised 4-phase req/ack receiver with LED and 7-seg readout.
// Define LAB6_SLAVE_ACK_TIMEOUT_EN to abandon a handshake whose request stays high too long.
module lab6_practice_slave #(
`ifdef LAB6_SLAVE_ACK_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
`endif
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned REFRESH_BITS   = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       request,
    input  logic [3:0] data_in,
    output logic       ack,
    output logic [7:0] led,
    output logic       err,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
`ifdef LAB6_SLAVE_ACK_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;
`endif

    logic          r_req_meta, r_req_s, r_req_d;
    logic [3:0]    r_data_meta, r_data_s;
    logic [1:0]    r_state;
    logic [SW-1:0] r_settle_cnt;
    logic          r_ack, r_err, r_rx_valid, r_code_bad;
    logic [7:0]    r_led;
    logic [2:0]    r_code;
    logic [3:0]    r_ones, r_tens;
    logic [REFRESH_BITS-1:0] r_scan;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_rise;
    logic [1:0]    w_sel;
    logic [6:0]    w_glyph;
    logic [3:0]    w_an_next;

    assign w_rise = r_req_s & ~r_req_d;
    assign w_sel  = r_scan[REFRESH_BITS-1 -: 2];

    assign ack = r_ack;
    assign led = r_led;
    assign err = r_err;
    assign seg = r_seg;
    assign an  = r_an;

    // Active-high gfedcba pattern for a BCD digit.
    function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_meta   <= 1'b0;
            r_req_s      <= 1'b0;
            r_req_d      <= 1'b0;
            r_data_meta  <= 4'd0;
            r_data_s     <= 4'd0;
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_led        <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_code_bad   <= 1'b0;
            r_code       <= 3'd0;
            r_ones       <= 4'd0;
            r_tens       <= 4'd0;
`ifdef LAB6_SLAVE_ACK_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_req_meta  <= request;
            r_req_s     <= r_req_meta;
            r_req_d     <= r_req_s;
            r_data_meta <= data_in;
            r_data_s    <= r_data_meta;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (!r_req_s) begin
                        r_state <= S_IDLE;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
`ifdef LAB6_SLAVE_ACK_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                        if (r_data_s[3]) begin
                            r_led      <= 8'd0;
                            r_err      <= 1'b1;
                            r_code_bad <= 1'b1;
                        end else begin
                            r_led      <= 8'd1 << r_data_s[2:0];
                            r_err      <= 1'b0;
                            r_code_bad <= 1'b0;
                            r_rx_valid <= 1'b1;
                            r_code     <= r_data_s[2:0];
                            // Two-digit BCD count wrapping 99 -> 00.
                            if (r_ones == 4'd9) begin
                                r_ones <= 4'd0;
                                r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
                            end else begin
                                r_ones <= r_ones + 4'd1;
                            end
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (!r_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
`ifdef LAB6_SLAVE_ACK_TIMEOUT_EN
                    end else if (r_to_cnt == TIMEOUT_LAST) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_an_next        = 4'hF;
        w_an_next[w_sel] = 1'b0;
        w_glyph          = 7'h00;
        unique case (w_sel)
            2'd0: begin
                if (r_code_bad)      w_glyph = 7'h40;
                else if (r_rx_valid) w_glyph = bcd_glyph({1'b0, r_code});
                else                 w_glyph = 7'h00;
            end
            2'd1: w_glyph = 7'h00;
            2'd2: w_glyph = bcd_glyph(r_ones);
            2'd3: w_glyph = (r_tens == 4'd0) ? 7'h00 : bcd_glyph(r_tens);
        endcase
    end

    // seg and an share one register stage so the digit and its pattern always switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_seg  <= 7'h7F;
            r_an   <= 4'hF;
        end else begin
            r_scan <= r_scan + 1'b1;
            r_seg  <= ~w_glyph;
            r_an   <= w_an_next;
        end
    end

endmodule

// File: tb/tb_lab6_practice_slave.sv
// Directed bench for lab6_practice_slave: handshake latency, latch rules, display and BCD wrap.
module tb_lab6_practice_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       request = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       ack;
    logic [7:0] led;
    logic       err;
    logic [6:0] seg;
    logic [3:0] an;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_0     = 7'h40;
    localparam logic [6:0] G_1     = 7'h79;
    localparam logic [6:0] G_5     = 7'h12;
    localparam logic [6:0] G_9     = 7'h10;

    lab6_practice_slave #(
`ifdef LAB6_SLAVE_ACK_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .SETTLE_CYCLES (4),
        .REFRESH_BITS  (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .request(request),
        .data_in(data_in),
        .ack    (ack),
        .led    (led),
        .err    (err),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_digit(input int idx, output logic [6:0] s);
        logic [3:0] want;
        int n;
        want      = 4'hF;
        want[idx] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== want && n < 100);
        if (an !== want) check_val("an_wait_timeout", {28'd0, an}, {28'd0, want});
        s = seg;
    endtask

    task automatic check_digit(input string tag, input int idx, input logic [6:0] exp);
        logic [6:0] s;
        read_digit(idx, s);
        check_val(tag, {25'd0, s}, {25'd0, exp});
    endtask

    task automatic xfer(input logic [3:0] code);
        int n;
        @(negedge clk);
        data_in = code;
        request = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 50);
        check_val("ack_rise_edges", n, 7);
        @(negedge clk);
        request = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack && n < 50);
        check_val("ack_fall_edges", n, 3);
    endtask

    initial begin
        logic [6:0] s;
        logic       seen;
        int         n;

        // Reset values while held in reset
        #12;
        check_val("rst_ack", {31'd0, ack}, 0);
        check_val("rst_led", {24'd0, led}, 0);
        check_val("rst_err", {31'd0, err}, 0);
        check_val("rst_seg", {25'd0, seg}, {25'd0, G_BLANK});
        check_val("rst_an", {28'd0, an}, 32'hF);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("idle_ack", {31'd0, ack}, 0);
        check_val("idle_led", {24'd0, led}, 0);
        check_val("idle_err", {31'd0, err}, 0);

        // Anode scan order, starting at the first cycle of digit 0
        read_digit(3, s);
        read_digit(0, s);
        check_val("idle_digit0_blank", {25'd0, s}, {25'd0, G_BLANK});
        repeat (4) @(negedge clk);
        check_val("scan_an1", {28'd0, an}, 32'hD);
        repeat (4) @(negedge clk);
        check_val("scan_an2", {28'd0, an}, 32'hB);
        repeat (4) @(negedge clk);
        check_val("scan_an3", {28'd0, an}, 32'h7);

        // Valid code 5
        xfer(4'd5);
        check_val("c5_led", {24'd0, led}, 32'h20);
        check_val("c5_err", {31'd0, err}, 0);
        check_digit("c5_digit0", 0, G_5);
        check_digit("c5_digit1", 1, G_BLANK);
        check_digit("c5_digit2", 2, G_1);
        check_digit("c5_digit3", 3, G_BLANK);

        // Abort while settling: request dropped before sampling
        @(negedge clk);
        data_in = 4'd6;
        request = 1'b1;
        repeat (3) @(negedge clk);
        request = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ack) seen = 1'b1;
        end
        check_val("abort_no_ack", {31'd0, seen}, 0);
        check_val("abort_led", {24'd0, led}, 32'h20);
        check_val("abort_err", {31'd0, err}, 0);
        check_digit("abort_digit2", 2, G_1);

        // Invalid code 8
        xfer(4'd8);
        check_val("c8_led", {24'd0, led}, 0);
        check_val("c8_err", {31'd0, err}, 1);
        check_digit("c8_digit0", 0, G_DASH);
        check_digit("c8_digit2", 2, G_1);
        check_digit("c8_digit3", 3, G_BLANK);

        // Reset in the middle of a handshake
        @(negedge clk);
        data_in = 4'd3;
        request = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 50);
        check_val("mid_ack_up", {31'd0, ack}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ack", {31'd0, ack}, 0);
        check_val("mid_rst_led", {24'd0, led}, 0);
        check_val("mid_rst_err", {31'd0, err}, 0);
        check_val("mid_rst_an", {28'd0, an}, 32'hF);
        request = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_digit("post_rst_digit0", 0, G_BLANK);

        // 100 transfers of code 0: count reaches 99 then wraps to 00
        for (int i = 1; i <= 100; i++) begin
            xfer(4'd0);
            if (i == 99) begin
                check_digit("cnt99_digit2", 2, G_9);
                check_digit("cnt99_digit3", 3, G_9);
            end
        end
        check_val("c0_led", {24'd0, led}, 32'h01);
        check_digit("wrap_digit0", 0, G_0);
        check_digit("wrap_digit2", 2, G_0);
        check_digit("wrap_digit3", 3, G_BLANK);

        // Request held high after ack
        @(negedge clk);
        data_in = 4'd2;
        request = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 50);
        check_val("hold_ack_rise_edges", n, 7);
`ifdef LAB6_SLAVE_ACK_TIMEOUT_EN
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack && n < 100);
        check_val("timeout_ack_cycles", n, 16);
        check_val("timeout_err", {31'd0, err}, 1);
        check_val("timeout_led", {24'd0, led}, 32'h04);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ack) seen = 1'b1;
        end
        check_val("timeout_no_reack", {31'd0, seen}, 0);
        @(negedge clk);
        request = 1'b0;
        repeat (5) @(negedge clk);
`else
        seen = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (!ack) seen = 1'b0;
        end
        check_val("hold_ack_stays", {31'd0, seen}, 1);
        check_val("hold_led", {24'd0, led}, 32'h04);
        check_val("hold_err", {31'd0, err}, 0);
        @(negedge clk);
        request = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack && n < 50);
        check_val("hold_ack_fall_edges", n, 3);
`endif
        check_digit("final_digit2", 2, G_1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
